hc165_key_reader: RTL and testbench

//  Periodically reads NBITS switch/key inputs through a daisy-chained 74HC165

---
 rtl/hc165_key_reader.sv | 151 +++++++++++++++
 tb/tb_hc165_key_reader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/hc165_key_reader.sv
// hc165_key_reader
// Scans a daisy-chained 74HC165 input register at a fixed tick rate and
// debounces every captured frame. It publishes the debounced switch state and
// one-clock rise/fall pulses per bit, plus a pulse at the end of every raw frame.
module hc165_key_reader #(
  parameter int CLK_DIV    = 300,
  parameter int NBITS      = 16,
  parameter int DEB_FRAMES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             sh_ld_n,
  output logic             sh_clk,
  input  logic             sh_din,
  output logic [NBITS-1:0] sw_state,
  output logic [NBITS-1:0] sw_rise,
  output logic [NBITS-1:0] sw_fall,
  output logic             frame_done
);

  localparam int            DW       = $clog2(CLK_DIV);
  localparam int            BW       = $clog2(NBITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NBITS - 1);
  localparam logic [7:0]    DEB_N    = 8'(DEB_FRAMES);

  // GAP is a quiet tick between frames so a frame spans 2*NBITS+3 ticks.
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT_S, SHIFT_H, UPDATE, GAP} state_t;

  state_t           state, state_next;
  logic [DW-1:0]    div_cnt;
  logic             tick;
  logic [BW-1:0]    bit_cnt, bit_cnt_next;
  logic [NBITS-1:0] shreg, shreg_next;
  logic [NBITS-1:0] cand, cand_next;
  logic [7:0]       deb_cnt, deb_cnt_next, deb_cnt_upd;
  logic             first_frame, first_frame_next;
  logic             sh_ld_n_next, sh_clk_next, frame_done_next;
  logic [NBITS-1:0] sw_state_next, sw_rise_next, sw_fall_next;
  logic             frame_differs, accept;

  assign tick = (div_cnt == DIV_LAST);

  // Free-running tick divider; the tick is a clock enable, not a derived clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Debounce bookkeeping for the frame held in shreg: the run counter restarts
  // on any change and saturates, so a steady state cannot be re-accepted.
  assign frame_differs = (shreg != cand);
  assign deb_cnt_upd   = frame_differs ? 8'd1 :
                         ((deb_cnt < DEB_N) ? deb_cnt + 8'd1 : deb_cnt);
  assign accept        = first_frame || ((deb_cnt_upd == DEB_N) && (shreg != sw_state));

  // Next-state and output logic: one FSM action per tick, pulses default low.
  always_comb begin
    state_next       = state;
    bit_cnt_next     = bit_cnt;
    shreg_next       = shreg;
    cand_next        = cand;
    deb_cnt_next     = deb_cnt;
    first_frame_next = first_frame;
    sh_ld_n_next     = sh_ld_n;
    sh_clk_next      = sh_clk;
    sw_state_next    = sw_state;
    sw_rise_next     = '0;
    sw_fall_next     = '0;
    frame_done_next  = 1'b0;
    if (tick) begin
      case (state)
        IDLE: begin
          sh_ld_n_next = 1'b0;
          sh_clk_next  = 1'b0;
          state_next   = LOAD;
        end
        LOAD: begin
          sh_ld_n_next = 1'b1;
          bit_cnt_next = '0;
          state_next   = SHIFT_S;
        end
        SHIFT_S: begin
          // QH has had a full tick to settle since PL# rose or CLK rose.
          shreg_next = {shreg[NBITS-2:0], sh_din};
          if (bit_cnt == BIT_LAST) begin
            state_next = UPDATE;
          end else begin
            sh_clk_next = 1'b1;
            state_next  = SHIFT_H;
          end
        end
        SHIFT_H: begin
          sh_clk_next  = 1'b0;
          bit_cnt_next = bit_cnt + BW'(1);
          state_next   = SHIFT_S;
        end
        UPDATE: begin
          cand_next       = shreg;
          deb_cnt_next    = deb_cnt_upd;
          frame_done_next = 1'b1;
          if (accept) begin
            sw_state_next    = shreg;
            first_frame_next = 1'b0;
            // The first state after reset is a snapshot, not an edge.
            if (!first_frame) begin
              sw_rise_next = shreg & ~sw_state;
              sw_fall_next = ~shreg & sw_state;
            end
          end
          state_next = GAP;
        end
        GAP:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State and output registers; reset drops any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shreg       <= '0;
      cand        <= '0;
      deb_cnt     <= '0;
      first_frame <= 1'b1;
      sh_ld_n     <= 1'b1;
      sh_clk      <= 1'b0;
      sw_state    <= '0;
      sw_rise     <= '0;
      sw_fall     <= '0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_next;
      bit_cnt     <= bit_cnt_next;
      shreg       <= shreg_next;
      cand        <= cand_next;
      deb_cnt     <= deb_cnt_next;
      first_frame <= first_frame_next;
      sh_ld_n     <= sh_ld_n_next;
      sh_clk      <= sh_clk_next;
      sw_state    <= sw_state_next;
      sw_rise     <= sw_rise_next;
      sw_fall     <= sw_fall_next;
      frame_done  <= frame_done_next;
    end
  end

endmodule

// File: tb/tb_hc165_key_reader.sv
// tb_hc165_key_reader
// Drives the reader through a behavioural 2x74HC165 chain and checks the
// protocol and the debounced outputs against a frame-history reference model.
module tb_hc165_key_reader;

  localparam int DIV       = 4;
  localparam int NB        = 16;
  localparam int DEB       = 3;
  localparam int FRAME_CLK = DIV * (2 * NB + 3);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          sh_ld_n, sh_clk, sh_din, frame_done;
  logic [NB-1:0] sw_state, sw_rise, sw_fall;

  logic [NB-1:0] sw_in;
  logic [NB-1:0] chain;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int last_done;
  int ld_low, rises;
  logic prev_clk;

  // reference model state
  logic [NB-1:0] m_state;
  bit            m_first;
  logic [NB-1:0] hist[$];

  hc165_key_reader #(.CLK_DIV(DIV), .NBITS(NB), .DEB_FRAMES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .sh_ld_n(sh_ld_n), .sh_clk(sh_clk), .sh_din(sh_din),
    .sw_state(sw_state), .sw_rise(sw_rise), .sw_fall(sw_fall), .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 74HC165 chain: PL# low loads the switches, CLK rising shifts toward QH
  always @(posedge sh_clk or negedge sh_ld_n) begin
    if (!sh_ld_n) chain <= sw_in;
    else          chain <= {chain[NB-2:0], 1'b0};
  end
  assign sh_din = chain[NB-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Model: the first frame after reset is taken as-is; afterwards a frame is
  // accepted when the last DEB frames are identical and differ from the state.
  task automatic model_frame(input logic [NB-1:0] f);
    logic [NB-1:0] er, ef;
    bit acc;
    er = '0;
    ef = '0;
    hist.push_back(f);
    if (hist.size() > DEB) void'(hist.pop_front());
    acc = m_first;
    if (!m_first && hist.size() == DEB && f != m_state) begin
      acc = 1'b1;
      foreach (hist[i]) if (hist[i] != f) acc = 1'b0;
    end
    if (acc) begin
      if (!m_first) begin
        er = f & ~m_state;
        ef = ~f & m_state;
      end
      m_state = f;
      m_first = 1'b0;
    end
    chk("sw_state", 32'(sw_state), 32'(m_state));
    chk("sw_rise", 32'(sw_rise), 32'(er));
    chk("sw_fall", 32'(sw_fall), 32'(ef));
  endtask

  task automatic wait_frame();
    bit got = 1'b0;
    int n = 0;
    while (!got && n < FRAME_CLK * 3) begin
      @(negedge clk);
      n++;
      if (!sh_ld_n) ld_low++;
      if (sh_clk && !prev_clk) rises++;
      prev_clk = sh_clk;
      if (frame_done) got = 1'b1;
      else chk("no_pulse", {sw_rise, sw_fall}, 32'h0);
    end
    chk("frame_done_seen", 32'(got), 32'd1);
    if (got) begin
      chk("ld_low_clk", ld_low, DIV);
      chk("sh_clk_rises", rises, NB - 1);
      if (last_done >= 0) chk("frame_period", cyc - last_done, FRAME_CLK);
      last_done = cyc;
      ld_low    = 0;
      rises     = 0;
      model_frame(sw_in);
      $display("frame in=%h state=%h rise=%h fall=%h", sw_in, sw_state, sw_rise, sw_fall);
    end
  endtask

  initial begin
    int r, n;
    rst_n     = 1'b0;
    sw_in     = '0;
    m_first   = 1'b1;
    m_state   = '0;
    last_done = -1;
    ld_low    = 0;
    rises     = 0;
    prev_clk  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sh_ld_n", 32'(sh_ld_n), 32'd1);
    chk("rst_sh_clk", 32'(sh_clk), 32'd0);
    chk("rst_sw_state", 32'(sw_state), 32'd0);
    chk("rst_pulses", {sw_rise, sw_fall}, 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);

    // initial state from reset: snapshot without pulses
    sw_in = 16'hA5C3;
    rst_n = 1'b1;
    repeat (3) wait_frame();
    chk("t2_state", 32'(sw_state), 32'h0000A5C3);

    // debounced multi-bit change
    sw_in = 16'h2542;
    repeat (3) wait_frame();
    chk("t3_state", 32'(sw_state), 32'h00002542);

    // bounce on bit 4 shorter than the debounce window
    sw_in = 16'h2542 ^ 16'h0010;
    repeat (2) wait_frame();
    sw_in = 16'h2542;
    repeat (4) wait_frame();
    chk("t4_state", 32'(sw_state), 32'h00002542);

    // reset while shifting, on the 8th sh_clk rise of a frame
    r = 0;
    n = 0;
    prev_clk = sh_clk;
    while (r < 8 && n < FRAME_CLK) begin
      @(negedge clk);
      n++;
      if (sh_clk && !prev_clk) r++;
      prev_clk = sh_clk;
    end
    chk("t5_rises_before_rst", r, 8);
    chk("t5_pre_sh_clk", 32'(sh_clk), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_sh_clk", 32'(sh_clk), 32'd0);
    chk("t5_sh_ld_n", 32'(sh_ld_n), 32'd1);
    chk("t5_sw_state", 32'(sw_state), 32'd0);
    chk("t5_pulses", {sw_rise, sw_fall}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    m_first   = 1'b1;
    m_state   = '0;
    hist.delete();
    last_done = -1;
    ld_low    = 0;
    rises     = 0;
    prev_clk  = sh_clk;
    sw_in     = 16'($urandom);
    rst_n     = 1'b1;
    repeat (3) wait_frame();

    // steady inputs: saturated counter must not re-fire
    repeat (20) wait_frame();

    // random holds and bit flips, some shorter than the debounce window
    repeat (12) begin
      if ($urandom_range(1, 0) == 1) sw_in = 16'($urandom);
      else sw_in = sw_in ^ (16'd1 << $urandom_range(NB - 1, 0));
      repeat ($urandom_range(4, 1)) wait_frame();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
